pwm_apb_sequencer: RTL and testbench

//  APB master that feeds duty-cycle updates into the PWM controller's APB slave port.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_req_fifo.sv | 56 +++++
 rtl/pwm_apb_sequencer.sv | 149 ++++++++++++++
 tb/tb_pwm_apb_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM APB sequencer.
//   pwm_state_e : sequencer FSM states
//   pwm_req_t   : one request word {ch, duty, commit}, 20 bits packed
//   duty_addr() : byte address of a channel's duty register
package pwm_pkg;

  localparam logic [11:0] PWM_DUTY_BASE   = 12'h020;
  localparam logic [11:0] PWM_COMMIT_ADDR = 12'h004;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StCSetup,
    StCAccess
  } pwm_state_e;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] duty;
    logic        commit;
  } pwm_req_t;

  // Channel n lives at base + 4*n; 12-bit arithmetic wraps silently.
  function automatic logic [11:0] duty_addr(input logic [11:0] base, input logic [2:0] ch);
    return base + {7'b0, ch, 2'b00};
  endfunction

endpackage

// File: rtl/pwm_req_fifo.sv
// Synchronous request FIFO.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i, wdata_i   : write strobe and data (ignored while full)
//   pop_i, rdata_o    : read strobe (ignored while empty), head-of-queue data
//   full_o, empty_o   : occupancy flags
//   level_o           : number of stored entries
module pwm_req_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end
  end

endmodule

// File: rtl/pwm_apb_sequencer.sv
// APB master feeding duty-cycle updates into the PWM controller.
//   pclk_i, preset_n_i         : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    : request handshake; req_ch_i, req_duty_i, req_commit_i payload
//   m_psel_o ... m_pwdata_o    : APB master request (registered)
//   m_pready_i, m_pslverr_i    : APB slave response
//   err_clr_i, err_o           : sticky error (slave error or timeout) and its clear
//   busy_o, level_o            : activity flag and FIFO occupancy
module pwm_apb_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [11:0] DUTY_BASE   = PWM_DUTY_BASE,
  parameter logic [11:0] COMMIT_ADDR = PWM_COMMIT_ADDR,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                          pclk_i,
  input  logic                          preset_n_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [2:0]                    req_ch_i,
  input  logic [15:0]                   req_duty_i,
  input  logic                          req_commit_i,
  output logic                          m_psel_o,
  output logic                          m_penable_o,
  output logic                          m_pwrite_o,
  output logic [11:0]                   m_paddr_o,
  output logic [31:0]                   m_pwdata_o,
  input  logic                          m_pready_i,
  input  logic                          m_pslverr_i,
  input  logic                          err_clr_i,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  pwm_state_e  state_q;
  logic        psel_q, penable_q, commit_q, err_q;
  logic [11:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [7:0]  cnt_q;

  pwm_req_t    push_word, head;
  logic        fifo_full, fifo_empty, pop;
  logic        in_access, timeout, err_set;

  assign push_word = '{ch: req_ch_i, duty: req_duty_i, commit: req_commit_i};

  pwm_req_fifo #(
    .Width ($bits(pwm_req_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (pclk_i),
    .rst_ni  (preset_n_i),
    .push_i  (req_valid_i),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign pop       = (state_q == StIdle) && !fifo_empty;
  assign in_access = (state_q == StAccess) || (state_q == StCAccess);
  assign timeout   = (cnt_q == TimeoutLast);
  // A completing access reports pslverr; a stalled one reports only on expiry.
  assign err_set   = in_access && (m_pready_i ? m_pslverr_i : timeout);

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      commit_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q   <= StSetup;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= duty_addr(DUTY_BASE, head.ch);
            pwdata_q  <= {16'h0000, head.duty};
            commit_q  <= head.commit;
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        StCSetup: begin
          state_q   <= StCAccess;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        StAccess, StCAccess: begin
          if (m_pready_i) begin
            if ((state_q == StAccess) && commit_q) begin
              // Slave error on the duty write still lets the commit go out.
              state_q   <= StCSetup;
              penable_q <= 1'b0;
              paddr_q   <= COMMIT_ADDR;
              pwdata_q  <= 32'h0000_0001;
            end else begin
              state_q   <= StIdle;
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
            end
          end else if (timeout) begin
            // Abandon the transfer; any pending commit is dropped.
            state_q   <= StIdle;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state_q != StIdle);
  assign err_o       = err_q;
  assign m_psel_o    = psel_q;
  assign m_penable_o = penable_q;
  assign m_pwrite_o  = psel_q;
  assign m_paddr_o   = paddr_q;
  assign m_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_pwm_apb_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// APB slave model that predicts each transfer from the queue of pushed words.
module tb_pwm_apb_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_ch = '0;
  logic [15:0] req_duty = '0;
  logic        req_commit = 1'b0;
  logic        m_psel, m_penable, m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pready;
  logic        slv_pready = 1'b0;
  logic        man_pready = 1'b0;
  logic        m_pslverr = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy, err;
  logic [2:0]  level;

  assign m_pready = slv_pready | man_pready;

  always #5 clk = ~clk;

  pwm_apb_sequencer dut (
    .pclk_i       (clk),
    .preset_n_i   (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_ch_i     (req_ch),
    .req_duty_i   (req_duty),
    .req_commit_i (req_commit),
    .m_psel_o     (m_psel),
    .m_penable_o  (m_penable),
    .m_pwrite_o   (m_pwrite),
    .m_paddr_o    (m_paddr),
    .m_pwdata_o   (m_pwdata),
    .m_pready_i   (m_pready),
    .m_pslverr_i  (m_pslverr),
    .err_clr_i    (err_clr),
    .busy_o       (busy),
    .err_o        (err),
    .level_o      (level)
  );

  typedef struct {
    int ch;
    int duty;
    bit commit;
  } word_t;

  typedef struct {
    int wt;
    bit e;
  } plan_t;

  word_t exp_q[$];
  plan_t plan_q[$];
  bit    model_err = 1'b0;
  bit    slave_en = 1'b1;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_plan(input int wt, input bit e);
    plan_t p;
    p.wt = wt;
    p.e  = e;
    plan_q.push_back(p);
  endtask

  // One accepted word per call; the model queue is appended at the accepting edge.
  task automatic push(input int ch, input int duty, input bit commit);
    int    n;
    word_t w;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_ch     = 3'(ch);
    req_duty   = 16'(duty);
    req_commit = commit;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("push_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    w.ch = ch; w.duty = duty; w.commit = commit;
    exp_q.push_back(w);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    model_err = 1'b0;
    check_eq({tag, "_err_cleared"}, 32'(err), 32'd0);
  endtask

  task automatic wait_psel(input string tag);
    int n;
    n = 0;
    while (!m_psel && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_psel_seen"}, 32'(m_psel), 32'd1);
  endtask

  // APB slave + transfer checker; sits on falling edges only.
  initial begin : slave
    word_t w;
    bit    commit_next, commit_after, done, e;
    int    wt, exp_addr, exp_data;
    plan_t p;
    commit_next = 1'b0;
    w.ch = 0; w.duty = 0; w.commit = 1'b0;
    @(negedge clk);
    forever begin
      if (slave_en && rst_n && m_psel && !m_penable) begin
        if (commit_next) begin
          exp_addr = 32'h004;
          exp_data = 32'h1;
        end else if (exp_q.size() == 0) begin
          check_eq("spurious_transfer", 32'(m_psel), 32'd0);
          w.ch = 0; w.duty = 0; w.commit = 1'b0;
          exp_addr = -1;
          exp_data = -1;
        end else begin
          w = exp_q.pop_front();
          exp_addr = (32'h020 + 4 * w.ch) & 32'hFFF;
          exp_data = w.duty & 32'hFFFF;
        end
        check_eq("setup_paddr", 32'(m_paddr), exp_addr);
        check_eq("setup_pwdata", m_pwdata, exp_data);
        check_eq("setup_pwrite", 32'(m_pwrite), 32'd1);
        if (plan_q.size() != 0) begin
          p  = plan_q.pop_front();
          wt = p.wt;
          e  = p.e;
        end else begin
          wt = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
          e  = ($urandom_range(0, 7) == 0);
        end
        done = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
          @(negedge clk);
          check_eq("access_sel_en", {30'd0, m_psel, m_penable}, 32'd3);
          check_eq("access_paddr_stable", 32'(m_paddr), exp_addr);
          if (k == wt) begin
            slv_pready = 1'b1;
            m_pslverr  = e;
            done       = 1'b1;
            break;
          end
        end
        @(negedge clk);
        slv_pready = 1'b0;
        m_pslverr  = 1'b0;
        if (!done || e) model_err = 1'b1;
        commit_after = !commit_next && done && w.commit;
        check_eq("after_psel", 32'(m_psel), 32'(commit_after));
        check_eq("after_penable", 32'(m_penable), 32'd0);
        check_eq("after_err", 32'(err), 32'(model_err));
        commit_next = commit_after;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    // Reset values
    #12;
    check_eq("rst_psel", 32'(m_psel), 32'd0);
    check_eq("rst_penable", 32'(m_penable), 32'd0);
    check_eq("rst_pwrite", 32'(m_pwrite), 32'd0);
    check_eq("rst_paddr", 32'(m_paddr), 32'd0);
    check_eq("rst_pwdata", m_pwdata, 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single write, immediate ready
    add_plan(0, 1'b0);
    push(3, 16'h1234, 1'b0);
    wait_psel("t1");
    n = 0;
    while (m_psel && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_eq("t1_psel_cycles", 32'(n), 32'd2);
    check_eq("t1_busy_low", 32'(busy), 32'd0);
    drain("t1");

    // 2: write plus commit, select held through the commit write
    add_plan(0, 1'b0);
    add_plan(0, 1'b0);
    push(0, 16'h0080, 1'b1);
    wait_psel("t2");
    n = 0;
    while (m_psel && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_eq("t2_psel_cycles", 32'(n), 32'd4);
    drain("t2");

    // 3: stall first transfer while five words are pushed
    add_plan(10, 1'b0);
    for (int i = 0; i < 4; i++) add_plan(0, 1'b0);
    for (int i = 0; i < 5; i++) push(i + 1, 16'h0100 + i, 1'b0);
    check_eq("t3_level_full", 32'(level), 32'd4);
    check_eq("t3_ready_low", 32'(req_ready), 32'd0);
    check_eq("t3_busy", 32'(busy), 32'd1);
    drain("t3");
    check_eq("t3_ready_back", 32'(req_ready), 32'd1);
    check_eq("t3_level_empty", 32'(level), 32'd0);

    // 4: timeout on a committing write, next word proceeds
    add_plan(99, 1'b0);
    add_plan(0, 1'b0);
    push(7, 16'hABCD, 1'b1);
    push(2, 16'h0042, 1'b0);
    drain("t4");
    check_eq("t4_err_sticky", 32'(err), 32'd1);
    clear_err("t4");

    // 5: slave error on duty write, commit still issued
    add_plan(0, 1'b1);
    add_plan(1, 1'b0);
    push(6, 16'h7777, 1'b1);
    drain("t5");
    check_eq("t5_err_sticky", 32'(err), 32'd1);
    clear_err("t5");

    // Randomized traffic; the slave picks waits, errors and occasional timeouts
    for (int i = 0; i < 40; i++) begin
      push(int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
           bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("rand");
    check_eq("rand_err", 32'(err), 32'(model_err));
    clear_err("rand");

    // 6: reset in the middle of an access
    slave_en = 1'b0;
    push(5, 16'h0055, 1'b1);
    push(1, 16'h0011, 1'b0);
    n = 0;
    while (!(m_psel && m_penable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_in_access", 32'(m_psel & m_penable), 32'd1);
    check_eq("t6_level_pre", 32'(level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_psel_async", 32'(m_psel), 32'd0);
    check_eq("t6_penable_async", 32'(m_penable), 32'd0);
    check_eq("t6_level_async", 32'(level), 32'd0);
    check_eq("t6_busy_async", 32'(busy), 32'd0);
    check_eq("t6_ready_async", 32'(req_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_psel) n++;
    end
    check_eq("t6_no_xfer_after_reset", 32'(n), 32'd0);
    check_eq("t6_idle_after_reset", 32'(busy), 32'd0);
    push(2, 16'hBEEF, 1'b0);
    exp_q.delete();
    wait_psel("t6_new");
    check_eq("t6_new_paddr", 32'(m_paddr), 32'h028);
    check_eq("t6_new_pwdata", m_pwdata, 32'h0000_BEEF);
    @(negedge clk);
    check_eq("t6_new_access", 32'(m_penable), 32'd1);
    man_pready = 1'b1;
    @(negedge clk);
    man_pready = 1'b0;
    check_eq("t6_new_done", 32'(m_psel), 32'd0);
    check_eq("t6_new_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
